// File: rtl/cube_frame_scheduler.sv
// LED cube refresh sequencer: double-buffered 64-byte frame store, latch/layer handshakes,
// dwell/blank timing, frame-boundary bank swaps. Optional dimming via CUBE_SCHED_DIM_EN.
module cube_frame_scheduler #(
  parameter int unsigned DWELL     = 2000,
  parameter int unsigned BLANK_CYC = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic       wr_en,
  input  logic [5:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic       swap_req,
  output logic       swap_busy,
  output logic       swap_ack,
  output logic       latch_start,
  output logic [2:0] latch_i,
  output logic [7:0] latch_data,
  input  logic       latch_done,
  output logic       layer_start,
  output logic [2:0] layer_i,
  input  logic       layer_done,
`ifdef CUBE_SCHED_DIM_EN
  input  logic [3:0] dim,
`endif
  output logic       layer_oe,
  output logic       frame_start
);

  localparam int unsigned CNT_MAX = (DWELL > BLANK_CYC) ? DWELL : BLANK_CYC;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_REQ, S_LOAD_WAIT, S_DRIVE_REQ, S_DRIVE_WAIT, S_DWELL, S_BLANK
  } state_t;

  state_t        state;
  logic [7:0]    mem [0:127];
  logic [7:0]    rd_data;
  logic          bank_sel;
  logic          swap_pend;
  logic          rd_pend;
  logic [2:0]    latch_idx;
  logic [CW-1:0] cnt;

`ifdef CUBE_SCHED_DIM_EN
  logic [CW-1:0] on_lim;
  logic [CW-1:0] dim_lim;
  assign dim_lim = CW'((DWELL * (32'(dim) + 32'd1)) / 32'd16);
`endif

  assign swap_busy = swap_pend;

  // Bank select picks the front half; writes always land in the other half.
  always_ff @(posedge clk) begin
    if (wr_en && !swap_pend)
      mem[{~bank_sel, wr_addr}] <= wr_data;
    rd_data <= mem[{bank_sel, layer_i, latch_idx}];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      bank_sel    <= 1'b0;
      swap_pend   <= 1'b0;
      swap_ack    <= 1'b0;
      rd_pend     <= 1'b0;
      latch_idx   <= '0;
      cnt         <= '0;
      latch_start <= 1'b0;
      latch_i     <= '0;
      latch_data  <= '0;
      layer_start <= 1'b0;
      layer_i     <= 3'd7;
      layer_oe    <= 1'b0;
      frame_start <= 1'b0;
`ifdef CUBE_SCHED_DIM_EN
      on_lim      <= '0;
`endif
    end else begin
      latch_start <= 1'b0;
      layer_start <= 1'b0;
      frame_start <= 1'b0;
      swap_ack    <= 1'b0;
      if (swap_req && !swap_pend)
        swap_pend <= 1'b1;

      case (state)
        S_IDLE: begin
          layer_oe <= 1'b0;
          if (swap_pend) begin
            bank_sel  <= ~bank_sel;
            swap_ack  <= 1'b1;
            swap_pend <= 1'b0;
          end
          if (run) begin
            state       <= S_LOAD_REQ;
            layer_i     <= 3'd7;
            latch_idx   <= '0;
            rd_pend     <= 1'b0;
            frame_start <= 1'b1;
          end
        end
        // First cycle issues the read, second presents the returned byte.
        S_LOAD_REQ: begin
          if (!rd_pend) begin
            rd_pend <= 1'b1;
          end else begin
            rd_pend     <= 1'b0;
            latch_start <= 1'b1;
            latch_i     <= latch_idx;
            latch_data  <= rd_data;
            state       <= S_LOAD_WAIT;
          end
        end
        S_LOAD_WAIT: begin
          if (latch_done) begin
            if (latch_idx != 3'd7) begin
              latch_idx <= latch_idx + 3'd1;
              state     <= S_LOAD_REQ;
            end else begin
              latch_idx <= '0;
              state     <= S_DRIVE_REQ;
            end
          end
        end
        S_DRIVE_REQ: begin
          layer_start <= 1'b1;
          state       <= S_DRIVE_WAIT;
        end
        S_DRIVE_WAIT: begin
          if (layer_done) begin
            state <= S_DWELL;
            cnt   <= CW'(DWELL - 1);
`ifdef CUBE_SCHED_DIM_EN
            on_lim   <= dim_lim;
            layer_oe <= (dim_lim != '0);
`else
            layer_oe <= 1'b1;
`endif
          end
        end
        S_DWELL: begin
          if (cnt == '0) begin
            state    <= S_BLANK;
            layer_oe <= 1'b0;
            cnt      <= CW'(BLANK_CYC - 1);
          end else begin
            cnt <= cnt - 1'b1;
`ifdef CUBE_SCHED_DIM_EN
            // Elapsed count on the next cycle is DWELL - cnt.
            layer_oe <= ((CW'(DWELL) - cnt) < on_lim);
`endif
          end
        end
        S_BLANK: begin
          if (cnt == '0) begin
            layer_i <= layer_i - 3'd1;
            if (layer_i == 3'd0 && swap_pend) begin
              bank_sel  <= ~bank_sel;
              swap_ack  <= 1'b1;
              swap_pend <= 1'b0;
            end
            if (run) begin
              state       <= S_LOAD_REQ;
              rd_pend     <= 1'b0;
              frame_start <= (layer_i == 3'd0);
            end else begin
              state <= S_IDLE;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/cube_frame_scheduler.md
# cube_frame_scheduler

Sequences the 8x8x8 LED cube refresh: a double-buffered 64-byte frame store feeds the latcher one byte per latch, then the layer activator for each layer, scanning layers 7 down to 0. Sits between the host-side pattern source and the `Latcher`/`LayerActivator` pair, replacing ad-hoc top-level load/drive sequencing. Owns dwell timing, inter-layer blanking and atomic frame swaps.

## Interface
- `DWELL`, 2000: clock cycles a layer stays lit after `layer_done`.
- `BLANK_CYC`, 16: cycles with `layer_oe`=0 between layers (anti-ghosting).
- `clk`  in  1  system clock, all logic on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `run`  in  1  level; 1 = scan continuously, 0 = stop at next layer boundary.
- `wr_en`  in  1  write strobe into back buffer.
- `wr_addr`  in  6  {layer[2:0], latch[2:0]}.
- `wr_data`  in  8  byte for that latch of that layer.
- `swap_req`  in  1  one-cycle pulse: request back/front exchange.
- `swap_busy`  out  1  high from cycle after `swap_req` until `swap_ack`.
- `swap_ack`  out  1  one-cycle pulse when swap has taken effect.
- `latch_start`  out  1  one-cycle pulse to latcher.
- `latch_i`  out  3  latch index, held stable from `latch_start` until `latch_done`.
- `latch_data`  out  8  byte, valid with and held like `latch_i`.
- `latch_done`  in  1  one-cycle pulse from latcher.
- `layer_start`  out  1  one-cycle pulse to layer activator.
- `layer_i`  out  3  layer index, held for whole layer.
- `layer_done`  in  1  one-cycle pulse from activator.
- `layer_oe`  out  1  layer output enable (1 = lit).
- `frame_start`  out  1  one-cycle pulse when layer 7 load begins.

## Operation
- States: IDLE, LOAD_REQ, LOAD_WAIT, DRIVE_REQ, DRIVE_WAIT, DWELL, BLANK.
- IDLE: `layer_oe`=0; leaves to LOAD_REQ when `run`=1, layer = 7, pulses `frame_start`.
- LOAD_REQ: synchronous read of front buffer at {layer_i, latch_idx}; next cycle pulse `latch_start` with `latch_i`/`latch_data`, go LOAD_WAIT. Latch order 0..7.
- LOAD_WAIT: on `latch_done`: latch_idx<7 -> increment, LOAD_REQ; latch_idx=7 -> DRIVE_REQ.
- DRIVE_REQ: pulse `layer_start`, go DRIVE_WAIT. On `layer_done` -> DWELL, `layer_oe`=1, counter loads DWELL-1.
- DWELL: count to 0 -> BLANK, `layer_oe`=0, counter loads BLANK_CYC-1.
- BLANK end: layer_i decrements (7->0); after layer 0 wraps to 7 (frame boundary). If `run`=0 -> IDLE, else LOAD_REQ (with `frame_start` on wrap).
- Swap: `swap_req` sets pending; at frame boundary (end of BLANK for layer 0, or immediately in IDLE) bank select toggles, `swap_ack` pulses same cycle, pending clears. `swap_req` while pending is ignored (no double toggle).
- Writes: to back buffer only; dropped while `swap_busy`=1. Write and read never touch the same bank.
- `latch_done`/`layer_done` outside their wait states are ignored.

## Timing
- Reset values: all pulse outputs 0, `layer_oe`=0, `layer_i`=7, `latch_i`=0, `latch_data`=0, `swap_busy`=0, state IDLE, bank select 0, buffer contents undefined (not reset).
- `latch_start` 2 cycles after entering LOAD_REQ (read latency 1).
- `layer_oe` rises the cycle after `layer_done`, high exactly DWELL cycles.
- Layer period = load time + activator time + DWELL + BLANK_CYC + 1.
- `rst_n` mid-layer: outputs return to reset values asynchronously; pending swap discarded.
- `run` deasserted mid-layer: current layer completes through BLANK, then IDLE.

## Configuration
- `CUBE_SCHED_DIM_EN` defined: adds input `dim` [3:0]; during DWELL `layer_oe`=1 only while dwell counter's elapsed count < (DWELL*(dim+1))/16 (computed once per layer at DWELL entry); `dim`=15 = full on.
- Undefined: no `dim` port; `layer_oe`=1 for the full DWELL.

## Test plan
- Reset, `run`=1, front buffer preloaded 8'h81,8'h42,... -> per layer 8 `latch_start` pulses, `latch_i` 0..7, data matches; `layer_i` sequence 7,6,...,0,7.
- DWELL=10, BLANK_CYC=4 -> `layer_oe` high exactly 10 cycles after `layer_done`, low 4 cycles before next load.
- Write all 8'hFF to back, `swap_req` mid-frame -> `swap_ack` at layer-0 BLANK end, next frame shows 8'hFF; write during `swap_busy` dropped.
- `run` dropped during layer 3 load -> layer 3 completes, IDLE, no further `latch_start`.
- `rst_n` low during DWELL -> `layer_oe`=0 immediately, `layer_i`=7.
- With `CUBE_SCHED_DIM_EN`, DWELL=16, `dim`=3 -> `layer_oe` high 4 cycles per layer.
